uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate in bits/s.
REQ-002 SHALL have parameter CLOCK_FREQ_HZ, default 12000000, meaning CLK frequency in Hz.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries, power of two, 2..16.
REQ-004 SHALL have port CLK  input  1  the single system clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port DATA  input  8  byte to transmit, sampled when VALID && READY.
REQ-007 SHALL have port VALID  input  1  DATA holds a byte to be sent.
REQ-008 SHALL have port READY  output  1  FIFO can accept a byte this cycle.
REQ-009 SHALL have port TX  output  1  serial line, idle high, registered output.
REQ-010 SHALL have port BUSY  output  1  high while a frame is in progress or the FIFO is non-empty.

Function
REQ-011 SHALL use BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE, integer division (1250 at defaults); every serial bit SHALL be held exactly BIT_PERIOD cycles.
REQ-012 SHALL send each frame as: start bit 0, 8 data bits LSB first, optional parity (REQ-026), stop bit 1.
REQ-013 SHALL accept a byte on a rising edge where VALID && READY; no other condition writes the FIFO.
REQ-014 READY SHALL equal "FIFO not full" and SHALL NOT depend combinationally on VALID or on a same-cycle pop.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START when FIFO non-empty (pop into shift register on that edge), START->DATA, DATA->PARITY (or STOP if parity compiled out) after 8th bit, PARITY->STOP, STOP->START if FIFO non-empty else IDLE, each transition after BIT_PERIOD cycles.
REQ-016 Byte accepted at edge N into an empty FIFO while IDLE SHALL be popped at edge N+1, with TX low from edge N+2.
REQ-017 Back-to-back frames SHALL have no idle gap: next start bit begins on the cycle after the last stop-bit cycle.
REQ-018 Simultaneous push and pop SHALL leave the FIFO count unchanged and preserve order.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL hold 0..FIFO_DEPTH inclusive.
REQ-020 A VALID held while READY is low SHALL be ignored without data loss or corruption of queued bytes.
REQ-021 BUSY SHALL go low on the cycle after the final stop-bit cycle when the FIFO is empty.

Reset
REQ-022 With RST high at a rising edge: TX=1, READY=1 (after the edge), BUSY=0, state=IDLE, FIFO empty, bit and cycle counters cleared.
REQ-023 RST asserted mid-frame SHALL abort the frame, return TX high on that edge, and discard all queued bytes.
REQ-024 A byte presented with VALID during an RST cycle SHALL NOT be accepted.
REQ-025 Power-up state without RST SHALL be TX=1 and IDLE (initial values).

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: even parity bit (XOR of 8 data bits) sent between data and stop, 11-bit frame; undefined: PARITY state unreachable/absent, 10-bit frame.

Verification
REQ-027 Defaults, push 0x31 ('1'), no parity -> TX low from edge N+2 then 0,1,0,0,0,1,1,0,0,1, each 1250 cycles; BUSY low afterwards.
REQ-028 UART_TX_PARITY_EN defined, push 0x31 -> parity bit 1 after data bits; push 0x33 -> parity bit 0; frame 11*1250 cycles.
REQ-029 VALID held high with 6 distinct bytes from idle -> 5 accepted at consecutive edges, READY low after 5th, 6th accepted when first frame's STOP ends; all 6 sent in order, no gaps.
REQ-030 Assert RST for one cycle at data bit 3 of a frame with 2 bytes queued -> TX=1 next edge, BUSY=0, READY=1, no further frames transmitted.
REQ-031 Push 0x00 then 0xFF back-to-back -> serial stream 0,00000000,1,0,11111111,1 with stop-to-start boundary exactly at cycle 12500.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter with a small byte FIFO: start bit, 8 data bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to insert an even parity bit between the data and stop bits.
module uart_tx #(
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned CLOCK_FREQ_HZ = 12000000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA,
  input  logic       VALID,
  output logic       READY,
  output logic       TX,
  output logic       BUSY
);

  localparam int unsigned BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CntW       = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int unsigned PtrW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CntW-1:0] LastCnt   = CntW'(BIT_PERIOD - 1);
  localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // Declaration initialisers give the power-up state when RST is never asserted.
  state_e          state_q  = StIdle;
  state_e          state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q = '0;
  logic [PtrW-1:0] rd_ptr_q = '0;
  logic [PtrW:0]   count_q  = '0;
  logic [CntW-1:0] cyc_q    = '0;
  logic [2:0]      bit_q    = '0;
  logic [7:0]      shift_q  = '0;
  logic            tx_q     = 1'b1;
  logic            busy_q   = 1'b0;
  logic            tx_d;
  logic            busy_d;
  logic            push;
  logic            pop;
  logic            bit_done;
  logic            fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic            parity_q = 1'b0;
`endif

  assign fifo_empty = (count_q == '0);
  assign READY      = (count_q != FullCount);
  assign push       = VALID && READY;
  assign bit_done   = (cyc_q == LastCnt);
  // Pop on leaving idle, or on the last stop-bit cycle so the next frame starts with no gap.
  assign pop        = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_done));
  assign TX         = tx_q;
  assign BUSY       = busy_q;

  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      mem_q[wr_ptr_q] <= DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + (PtrW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      if ((state_q == StIdle) || bit_done) cyc_q <= '0;
      else                                 cyc_q <= cyc_q + CntW'(1);
      if (pop) begin
        shift_q <= mem_q[rd_ptr_q];
      end else if ((state_q == StData) && bit_done) begin
        shift_q <= {1'b0, shift_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST)      parity_q <= 1'b0;
    else if (pop) parity_q <= ^mem_q[rd_ptr_q];
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (!fifo_empty) state_d = StStart;
      StStart:  if (bit_done) state_d = StData;
      StData: begin
        if (bit_done && (bit_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
      StParity: if (bit_done) state_d = StStop;
      StStop:   if (bit_done) state_d = fifo_empty ? StIdle : StStart;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != StIdle) || !fifo_empty;
    case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // TX and BUSY are registered, so both trail the state by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: queue-based line model plus directed frame checks.
// A short bit period (1e6 / 58000 = 17 cycles, truncated) keeps the run small.
module tb_uart_tx;

  localparam int BAUD  = 58000;
  localparam int CLKHZ = 1000000;
  localparam int DEPTH = 4;
  localparam int BP    = CLKHZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * BP;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;
  logic       TX;
  logic       BUSY;

  int errors = 0;
  int checks = 0;
  int edge_no = 0;

  uart_tx #(
    .BAUD_RATE    (BAUD),
    .CLOCK_FREQ_HZ(CLKHZ),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .DATA (DATA),
    .VALID(VALID),
    .READY(READY),
    .TX   (TX),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  // Line model: accepted bytes wait in q; a started frame becomes a per-cycle list of line levels.
  logic       sched[$];
  logic [7:0] q[$];
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ready = 1'b1;
  logic       m_quiet = 1'b1;
  logic       pend_busy = 1'b0;
  logic       m_acc;
  logic [7:0] m_byte;

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  always @(posedge CLK) begin
    edge_no++;
    if (RST) begin
      sched.delete();
      q.delete();
      m_tx = 1'b1;
      m_busy = 1'b0;
      m_ready = 1'b1;
      pend_busy = 1'b0;
      m_quiet = 1'b1;
    end else begin
      m_acc = VALID && (q.size() < DEPTH);
      m_busy = pend_busy;
      if (sched.size() > 0) m_tx = sched.pop_front();
      else m_tx = 1'b1;
      if (sched.size() == 0 && q.size() > 0) begin
        m_byte = q.pop_front();
        for (int i = 0; i < NB; i++)
          for (int j = 0; j < BP; j++) sched.push_back(frame_bit(m_byte, i));
      end
      if (m_acc) q.push_back(DATA);
      m_ready = (q.size() < DEPTH);
      pend_busy = (sched.size() > 0) || (q.size() > 0);
      m_quiet = !pend_busy;
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    checks++;
    if (TX !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL powerup tx,busy=%b%b required 10", TX, BUSY);
    end
    RST = 1'b1; VALID = 1'b1; DATA = 8'hA5;
    tick();
    checks++;
    if ({TX, BUSY, READY} !== 3'b101) begin
      errors++;
      $display("FAIL reset_state tx,busy,ready=%b%b%b required 101", TX, BUSY, READY);
    end
    RST = 1'b0; VALID = 1'b0;
    repeat (3 * BP) begin
      tick();
      checks++;
      if ({TX, BUSY, READY} !== {m_tx, m_busy, m_ready}) begin
        errors++;
        $display("FAIL reset_model tx,busy,ready=%b%b%b required %b%b%b",
                 TX, BUSY, READY, m_tx, m_busy, m_ready);
      end
    end
    checks++;
    if (TX !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept tx,busy=%b%b required 10", TX, BUSY);
    end
  endtask

  task automatic test_single(input logic [7:0] b, input logic [10:0] vec);
    VALID = 1'b1; DATA = b;
    tick();
    VALID = 1'b0;
    tick();
    checks++;
    if (TX !== 1'b1) begin
      errors++;
      $display("FAIL single_latency byte=%h tx=%b required 1 at edge N+1", b, TX);
    end
    for (int i = 0; i < NB; i++) begin
      repeat (BP) begin
        tick();
        checks++;
        if (TX !== vec[i] || BUSY !== 1'b1) begin
          errors++;
          $display("FAIL single_bit byte=%h bit=%0d tx,busy=%b%b required %b1",
                   b, i, TX, BUSY, vec[i]);
        end
      end
    end
    tick();
    checks++;
    if (BUSY !== 1'b0 || TX !== 1'b1) begin
      errors++;
      $display("FAIL single_end byte=%h tx,busy=%b%b required 10", b, TX, BUSY);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    int fi, bi;
    VALID = 1'b1; DATA = 8'h00;
    tick();
    DATA = 8'hFF;
    tick();
    VALID = 1'b0;
    for (int k = 0; k < 2 * F; k++) begin
      tick();
      fi = k / F;
      bi = (k % F) / BP;
      if (bi == 0) e = 1'b0;
      else if (bi == NB - 1) e = 1'b1;
      else if (bi <= 8) e = (fi == 1);
      else e = 1'b0;
      checks++;
      if (TX !== e || {TX, BUSY, READY} !== {m_tx, m_busy, m_ready}) begin
        errors++;
        $display("FAIL b2b_stream k=%0d tx,busy,ready=%b%b%b required tx=%b model=%b%b%b",
                 k, TX, BUSY, READY, e, m_tx, m_busy, m_ready);
      end
      if (k == F - 1 || k == F) begin
        checks++;
        if (TX !== (k == F - 1)) begin
          errors++;
          $display("FAIL b2b_boundary k=%0d tx=%b required %b", k, TX, (k == F - 1));
        end
      end
    end
    tick();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy_end busy=%b required 0", BUSY);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] vals[6];
    int acc_edge[6];
    int idx = 0;
    logic acc;
    for (int i = 0; i < 6; i++) vals[i] = 8'(8'h3C + 8'(i * 37));
    for (int k = 0; k < 4 * F && idx < 6; k++) begin
      VALID = 1'b1; DATA = vals[idx];
      acc = m_ready;
      tick();
      checks++;
      if ({TX, BUSY, READY} !== {m_tx, m_busy, m_ready}) begin
        errors++;
        $display("FAIL full_model tx,busy,ready=%b%b%b required %b%b%b",
                 TX, BUSY, READY, m_tx, m_busy, m_ready);
      end
      if (acc) begin
        acc_edge[idx] = edge_no;
        if (idx == DEPTH) begin
          checks++;
          if (READY !== 1'b0) begin
            errors++;
            $display("FAIL full_ready ready=%b required 0 after byte %0d", READY, idx + 1);
          end
        end
        idx++;
      end
    end
    VALID = 1'b0;
    checks++;
    if (idx != 6) begin
      errors++;
      $display("FAIL full_timeout accepted=%0d required 6", idx);
    end else begin
      for (int i = 1; i <= DEPTH; i++) begin
        checks++;
        if (acc_edge[i] - acc_edge[0] != i) begin
          errors++;
          $display("FAIL full_consecutive byte=%0d offset=%0d required %0d",
                   i, acc_edge[i] - acc_edge[0], i);
        end
      end
      checks++;
      if (acc_edge[5] - acc_edge[0] != F + 2) begin
        errors++;
        $display("FAIL full_sixth offset=%0d required %0d", acc_edge[5] - acc_edge[0], F + 2);
      end
    end
    for (int k = 0; k < 8 * F && !(m_quiet && !m_busy); k++) begin
      tick();
      checks++;
      if ({TX, BUSY, READY} !== {m_tx, m_busy, m_ready}) begin
        errors++;
        $display("FAIL full_drain tx,busy,ready=%b%b%b required %b%b%b",
                 TX, BUSY, READY, m_tx, m_busy, m_ready);
      end
    end
    checks++;
    if (BUSY !== 1'b0 || !m_quiet) begin
      errors++;
      $display("FAIL full_drain_end busy=%b required 0", BUSY);
    end
  endtask

  task automatic test_reset_midframe();
    VALID = 1'b1;
    DATA = 8'h5A; tick();
    DATA = 8'hC3; tick();
    DATA = 8'h96; tick();
    VALID = 1'b0;
    repeat (4 * BP + BP / 2) begin
      tick();
      checks++;
      if ({TX, BUSY, READY} !== {m_tx, m_busy, m_ready}) begin
        errors++;
        $display("FAIL mid_model tx,busy,ready=%b%b%b required %b%b%b",
                 TX, BUSY, READY, m_tx, m_busy, m_ready);
      end
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if ({TX, BUSY, READY} !== 3'b101) begin
      errors++;
      $display("FAIL mid_reset tx,busy,ready=%b%b%b required 101", TX, BUSY, READY);
    end
    repeat (2 * F) begin
      tick();
      checks++;
      if ({TX, BUSY, READY} !== 3'b101) begin
        errors++;
        $display("FAIL mid_silent tx,busy,ready=%b%b%b required 101", TX, BUSY, READY);
      end
    end
  endtask

  task automatic test_random();
    int sent = 0;
    for (int k = 0; k < 30 * F && sent < 12; k++) begin
      VALID = ($urandom_range(0, 3) != 0);
      DATA = 8'($urandom);
      if (VALID && m_ready) sent++;
      tick();
      checks++;
      if ({TX, BUSY, READY} !== {m_tx, m_busy, m_ready}) begin
        errors++;
        $display("FAIL random_model tx,busy,ready=%b%b%b required %b%b%b",
                 TX, BUSY, READY, m_tx, m_busy, m_ready);
      end
    end
    VALID = 1'b0;
    checks++;
    if (sent != 12) begin
      errors++;
      $display("FAIL random_budget sent=%0d required 12", sent);
    end
    for (int k = 0; k < 8 * F && !(m_quiet && !m_busy); k++) begin
      tick();
      checks++;
      if ({TX, BUSY, READY} !== {m_tx, m_busy, m_ready}) begin
        errors++;
        $display("FAIL random_drain tx,busy,ready=%b%b%b required %b%b%b",
                 TX, BUSY, READY, m_tx, m_busy, m_ready);
      end
    end
    checks++;
    if (BUSY !== 1'b0 || TX !== 1'b1) begin
      errors++;
      $display("FAIL random_end tx,busy=%b%b required 10", TX, BUSY);
    end
  endtask

  initial begin
    logic [10:0] v31;
    logic [10:0] v33;
`ifdef UART_TX_PARITY_EN
    v31 = 11'b11001100010;
    v33 = 11'b10001100110;
`else
    v31 = 11'b00_1001100010;
    v33 = 11'b00_1001100110;
`endif
    RST = 1'b0; VALID = 1'b0; DATA = 8'h00;
    #1;
    test_reset();
    test_single(8'h31, v31);
    test_single(8'h33, v33);
    test_back_to_back();
    test_fifo_full();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
